// File: rtl/osd_wr_scheduler_pkg.sv
// Shared OSD write scheduler definitions: write-word width, FSM encodings,
// and the gap counter sizing helper.
package osd_wr_scheduler_pkg;

  localparam int OSD_WR_W = 25;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT4VB = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_GAP     = 2'd3
  } wr_state_t;

  // Gap counter must hold 0..gap-1 but never collapse to zero width.
  function automatic int gap_width(input int gap);
    return (gap < 1) ? 1 : $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/osd_wr_scheduler_if.sv
// CPU-side write port and OSD RAM-side write port of the scheduler, plus
// the FSM state for observation.
interface osd_wr_scheduler_if #(parameter int FIFO_AW = 3);
  import osd_wr_scheduler_pkg::*;

  // WrReq_i is a push strobe with no ready: a word is taken every high cycle
  // (or dropped and flagged when full). OSDWrEn_o is a one-cycle valid with no
  // back-pressure; OSDWrVector_o is meaningful only while it is high.
  logic                WrReq_i;
  logic [OSD_WR_W-1:0] WrVector_i;
  logic                VBlank_i;
  logic                Flush_i;
  logic                OvfClr_i;
  logic [OSD_WR_W-1:0] OSDWrVector_o;
  logic                OSDWrEn_o;
  logic [FIFO_AW:0]    Level_o;
  logic                Full_o;
  logic                Overflow_o;
  wr_state_t           state_dbg;

  modport master (
    output WrReq_i, WrVector_i, VBlank_i, Flush_i, OvfClr_i,
    input  OSDWrVector_o, OSDWrEn_o, Level_o, Full_o, Overflow_o, state_dbg
  );

  modport slave (
    input  WrReq_i, WrVector_i, VBlank_i, Flush_i, OvfClr_i,
    output OSDWrVector_o, OSDWrEn_o, Level_o, Full_o, Overflow_o, state_dbg
  );

endinterface

// File: rtl/osd_wr_scheduler_fifo.sv
// Circular write FIFO: storage, wrapping pointers, occupancy, full/empty.
// Flush discards everything and wins over a concurrent push or pop.
module osd_wr_fifo
  import osd_wr_scheduler_pkg::*;
#(
  parameter int AW = 3,
  parameter int DW = OSD_WR_W
) (
  input  logic          SYS_CLK,
  input  logic          SYS_nRST,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty && !flush;
  // A full FIFO still accepts a push when a pop frees the head slot this cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge SYS_CLK or negedge SYS_nRST) begin
    if (!SYS_nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/osd_wr_scheduler.sv
// Queues CPU OSD writes and releases them to OSD RAM only during vertical
// blank, one word per issue with WR_GAP idle cycles between words.
module osd_wr_scheduler
  import osd_wr_scheduler_pkg::*;
#(
  parameter int FIFO_AW = 3,
  parameter int WR_GAP  = 2
) (
  input logic               SYS_CLK,
  input logic               SYS_nRST,
  osd_wr_scheduler_if.slave bus
);

  localparam int               GAP_W     = gap_width(WR_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);
  localparam logic [FIFO_AW:0] LEVEL_ONE = (FIFO_AW+1)'(1);

  wr_state_t           state, state_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_nxt;
  logic                pop;
  logic                pop_fire;
  logic                ovf_set;
  logic                fifo_empty;
  logic                fifo_full;
  logic [FIFO_AW:0]    fifo_level;
  logic [OSD_WR_W-1:0] fifo_head;

  osd_wr_fifo #(.AW(FIFO_AW), .DW(OSD_WR_W)) u_fifo (
    .SYS_CLK   (SYS_CLK),
    .SYS_nRST  (SYS_nRST),
    .flush     (bus.Flush_i),
    .push      (bus.WrReq_i),
    .push_data (bus.WrVector_i),
    .pop       (pop),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    pop         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_nxt = ST_WAIT4VB;
      end
      ST_WAIT4VB: begin
        if (fifo_empty)        state_nxt = ST_IDLE;
        else if (bus.VBlank_i) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        pop         = 1'b1;
        gap_cnt_nxt = '0;
        if (WR_GAP > 0)                                state_nxt = ST_GAP;
        else if (bus.VBlank_i && fifo_level > LEVEL_ONE) state_nxt = ST_ISSUE;
        else                                           state_nxt = ST_WAIT4VB;
      end
      ST_GAP: begin
        // The last gap cycle decides as WAIT4VB would, so strobes are WR_GAP+1 apart.
        if (gap_cnt != GAP_LAST) begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end else begin
          gap_cnt_nxt = '0;
          if (fifo_empty)        state_nxt = ST_IDLE;
          else if (bus.VBlank_i) state_nxt = ST_ISSUE;
          else                   state_nxt = ST_WAIT4VB;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (bus.Flush_i) begin
      state_nxt   = ST_IDLE;
      gap_cnt_nxt = '0;
      pop         = 1'b0;
    end
  end

  assign pop_fire = pop && !fifo_empty;
  assign ovf_set  = bus.WrReq_i && !bus.Flush_i && fifo_full && !pop_fire;

  always_ff @(posedge SYS_CLK or negedge SYS_nRST) begin
    if (!SYS_nRST) begin
      state             <= ST_IDLE;
      gap_cnt           <= '0;
      bus.OSDWrEn_o     <= 1'b0;
      bus.OSDWrVector_o <= '0;
      bus.Overflow_o    <= 1'b0;
    end else begin
      state         <= state_nxt;
      gap_cnt       <= gap_cnt_nxt;
      bus.OSDWrEn_o <= pop_fire;
      if (pop_fire) bus.OSDWrVector_o <= fifo_head;
      bus.Overflow_o <= ovf_set || (bus.Overflow_o && !bus.OvfClr_i);
    end
  end

  assign bus.Level_o   = fifo_level;
  assign bus.Full_o    = fifo_full;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_osd_wr_scheduler.sv
// Directed bench for osd_wr_scheduler: latency, overflow, vblank pausing,
// full push/pop, flush and asynchronous reset during a drain.
module tb_osd_wr_scheduler;
  import osd_wr_scheduler_pkg::*;

  logic SYS_CLK;
  logic SYS_nRST;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc     = 0;

  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];
  int          obs_t[$];

  osd_wr_scheduler_if #(.FIFO_AW(3)) bus ();

  osd_wr_scheduler #(.FIFO_AW(3), .WR_GAP(2)) dut (
    .SYS_CLK  (SYS_CLK),
    .SYS_nRST (SYS_nRST),
    .bus      (bus)
  );

  // clock / reset
  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  always @(posedge SYS_CLK) cyc <= cyc + 1;

  // strobe monitor
  always @(posedge SYS_CLK) begin
    #1;
    if (bus.OSDWrEn_o === 1'b1) begin
      obs_q.push_back(bus.OSDWrVector_o);
      obs_t.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge SYS_CLK);
  endtask

  task automatic push_word(input logic [24:0] w);
    bus.WrReq_i    = 1'b1;
    bus.WrVector_i = w;
    @(negedge SYS_CLK);
    bus.WrReq_i    = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge SYS_CLK);
  endtask

  task automatic test_reset;
    SYS_nRST = 1'b0;
    idle(2);
    vec_cnt++; if (bus.Level_o !== 4'd0) begin err_cnt++; $display("FAIL rst_level got %0d want 0", bus.Level_o); end
    vec_cnt++; if (bus.Full_o !== 1'b0) begin err_cnt++; $display("FAIL rst_full got %b want 0", bus.Full_o); end
    vec_cnt++; if (bus.Overflow_o !== 1'b0) begin err_cnt++; $display("FAIL rst_ovf got %b want 0", bus.Overflow_o); end
    vec_cnt++; if (bus.OSDWrEn_o !== 1'b0) begin err_cnt++; $display("FAIL rst_en got %b want 0", bus.OSDWrEn_o); end
    vec_cnt++; if (bus.OSDWrVector_o !== 25'h0) begin err_cnt++; $display("FAIL rst_vec got %h want 0", bus.OSDWrVector_o); end
    vec_cnt++; if (bus.state_dbg !== ST_IDLE) begin err_cnt++; $display("FAIL rst_state got %0d want %0d", bus.state_dbg, ST_IDLE); end
    SYS_nRST = 1'b1;
    idle(2);
  endtask

  task automatic test_latency;
    obs_q.delete(); obs_t.delete();
    bus.VBlank_i   = 1'b1;
    bus.WrReq_i    = 1'b1;
    bus.WrVector_i = 25'h1ABCDEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge SYS_CLK);
      bus.WrReq_i = 1'b0;
      vec_cnt++;
      if (bus.OSDWrEn_o !== (i == 3)) begin
        err_cnt++; $display("FAIL lat_en[%0d] got %b want %b", i, bus.OSDWrEn_o, (i == 3));
      end
      if (i == 3) begin
        vec_cnt++;
        if (bus.OSDWrVector_o !== 25'h1ABCDEF) begin
          err_cnt++; $display("FAIL lat_vec got %h want 1abcdef", bus.OSDWrVector_o);
        end
      end
    end
    idle(4);
  endtask

  task automatic test_overflow;
    logic [24:0] tab [9];
    tab = '{25'h0000A0, 25'h0000A1, 25'h0000A2, 25'h0000A3, 25'h0000A4,
            25'h0000A5, 25'h0000A6, 25'h0000A7, 25'h0000A8};
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    bus.VBlank_i = 1'b0;
    idle(1);
    for (int k = 0; k < 9; k++) begin
      push_word(tab[k]);
      if (k < 8) exp_q.push_back(tab[k]);
    end
    vec_cnt++; if (bus.Level_o !== 4'd8) begin err_cnt++; $display("FAIL ovf_level got %0d want 8", bus.Level_o); end
    vec_cnt++; if (bus.Full_o !== 1'b1) begin err_cnt++; $display("FAIL ovf_full got %b want 1", bus.Full_o); end
    vec_cnt++; if (bus.Overflow_o !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag got %b want 1", bus.Overflow_o); end
    vec_cnt++; if (obs_q.size() != 0) begin err_cnt++; $display("FAIL ovf_nostrobe got %0d want 0", obs_q.size()); end
    // clear and dropped push together: set wins
    bus.OvfClr_i = 1'b1;
    push_word(25'h0000A9);
    bus.OvfClr_i = 1'b0;
    vec_cnt++; if (bus.Overflow_o !== 1'b1) begin err_cnt++; $display("FAIL ovf_setwins got %b want 1", bus.Overflow_o); end
    bus.OvfClr_i = 1'b1;
    @(negedge SYS_CLK);
    bus.OvfClr_i = 1'b0;
    vec_cnt++; if (bus.Overflow_o !== 1'b0) begin err_cnt++; $display("FAIL ovf_clear got %b want 0", bus.Overflow_o); end
    bus.VBlank_i = 1'b1;
    wait_strobes(8, 60);
    vec_cnt++; if (obs_q.size() != 8) begin err_cnt++; $display("FAIL ovf_count got %0d want 8", obs_q.size()); end
    for (int k = 0; k < 8; k++) begin
      vec_cnt++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        err_cnt++; $display("FAIL ovf_word[%0d] got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : 25'h0, exp_q[k]);
      end
    end
    for (int k = 1; k < 8 && k < obs_t.size(); k++) begin
      vec_cnt++;
      if (obs_t[k] - obs_t[k-1] != 3) begin
        err_cnt++; $display("FAIL ovf_spacing[%0d] got %0d want 3", k, obs_t[k] - obs_t[k-1]);
      end
    end
    idle(4);
    vec_cnt++; if (bus.Level_o !== 4'd0) begin err_cnt++; $display("FAIL ovf_drained got %0d want 0", bus.Level_o); end
  endtask

  task automatic test_vblank_pause;
    logic [24:0] tab [4];
    tab = '{25'h1000001, 25'h0ACE123, 25'h0000BEE, 25'h1F0F0F0};
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    bus.VBlank_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_word(tab[k]);
      exp_q.push_back(tab[k]);
    end
    bus.VBlank_i = 1'b1;
    wait_strobes(1, 20);
    bus.VBlank_i = 1'b0;
    vec_cnt++; if (obs_q.size() != 1) begin err_cnt++; $display("FAIL pause_first got %0d want 1", obs_q.size()); end
    idle(12);
    vec_cnt++; if (obs_q.size() != 1) begin err_cnt++; $display("FAIL pause_held got %0d want 1", obs_q.size()); end
    vec_cnt++; if (bus.Level_o !== 4'd3) begin err_cnt++; $display("FAIL pause_level got %0d want 3", bus.Level_o); end
    bus.VBlank_i = 1'b1;
    wait_strobes(4, 30);
    vec_cnt++; if (obs_q.size() != 4) begin err_cnt++; $display("FAIL pause_count got %0d want 4", obs_q.size()); end
    for (int k = 0; k < 4; k++) begin
      vec_cnt++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        err_cnt++; $display("FAIL pause_word[%0d] got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : 25'h0, exp_q[k]);
      end
    end
    idle(4);
  endtask

  task automatic test_full_push_pop;
    logic [24:0] tab [9];
    tab = '{25'h0000D0, 25'h0000D1, 25'h0000D2, 25'h0000D3, 25'h0000D4,
            25'h0000D5, 25'h0000D6, 25'h0000D7, 25'h1D8D8D8};
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    bus.VBlank_i = 1'b0;
    for (int k = 0; k < 8; k++) push_word(tab[k]);
    for (int k = 0; k < 9; k++) exp_q.push_back(tab[k]);
    vec_cnt++; if (bus.Full_o !== 1'b1) begin err_cnt++; $display("FAIL fpp_full got %b want 1", bus.Full_o); end
    bus.VBlank_i = 1'b1;
    @(negedge SYS_CLK);
    push_word(tab[8]);
    vec_cnt++; if (bus.Level_o !== 4'd8) begin err_cnt++; $display("FAIL fpp_level got %0d want 8", bus.Level_o); end
    vec_cnt++; if (bus.Overflow_o !== 1'b0) begin err_cnt++; $display("FAIL fpp_ovf got %b want 0", bus.Overflow_o); end
    vec_cnt++; if (obs_q.size() != 1) begin err_cnt++; $display("FAIL fpp_popped got %0d want 1", obs_q.size()); end
    wait_strobes(9, 60);
    vec_cnt++; if (obs_q.size() != 9) begin err_cnt++; $display("FAIL fpp_count got %0d want 9", obs_q.size()); end
    for (int k = 0; k < 9; k++) begin
      vec_cnt++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        err_cnt++; $display("FAIL fpp_word[%0d] got %h want %h", k, (k < obs_q.size()) ? obs_q[k] : 25'h0, exp_q[k]);
      end
    end
    idle(4);
  endtask

  task automatic test_flush;
    obs_q.delete(); obs_t.delete();
    bus.VBlank_i = 1'b0;
    for (int k = 0; k < 5; k++) push_word(25'h0F0000 | 25'(k));
    vec_cnt++; if (bus.Level_o !== 4'd5) begin err_cnt++; $display("FAIL flush_pre got %0d want 5", bus.Level_o); end
    bus.Flush_i = 1'b1;
    push_word(25'h0F00FF);
    bus.Flush_i = 1'b0;
    vec_cnt++; if (bus.Level_o !== 4'd0) begin err_cnt++; $display("FAIL flush_level got %0d want 0", bus.Level_o); end
    vec_cnt++; if (bus.Overflow_o !== 1'b0) begin err_cnt++; $display("FAIL flush_ovf got %b want 0", bus.Overflow_o); end
    vec_cnt++; if (bus.state_dbg !== ST_IDLE) begin err_cnt++; $display("FAIL flush_state got %0d want %0d", bus.state_dbg, ST_IDLE); end
    bus.VBlank_i = 1'b1;
    idle(12);
    vec_cnt++; if (obs_q.size() != 0) begin err_cnt++; $display("FAIL flush_nostrobe got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_drain;
    obs_q.delete(); obs_t.delete();
    bus.VBlank_i = 1'b0;
    for (int k = 0; k < 6; k++) push_word(25'h0E0000 | 25'(k + 1));
    bus.VBlank_i = 1'b1;
    wait_strobes(1, 20);
    #2;
    SYS_nRST = 1'b0;
    #1;
    vec_cnt++; if (bus.Level_o !== 4'd0) begin err_cnt++; $display("FAIL arst_level got %0d want 0", bus.Level_o); end
    vec_cnt++; if (bus.Full_o !== 1'b0) begin err_cnt++; $display("FAIL arst_full got %b want 0", bus.Full_o); end
    vec_cnt++; if (bus.OSDWrEn_o !== 1'b0) begin err_cnt++; $display("FAIL arst_en got %b want 0", bus.OSDWrEn_o); end
    vec_cnt++; if (bus.OSDWrVector_o !== 25'h0) begin err_cnt++; $display("FAIL arst_vec got %h want 0", bus.OSDWrVector_o); end
    vec_cnt++; if (bus.state_dbg !== ST_IDLE) begin err_cnt++; $display("FAIL arst_state got %0d want %0d", bus.state_dbg, ST_IDLE); end
    @(negedge SYS_CLK);
    SYS_nRST = 1'b1;
    idle(15);
    vec_cnt++; if (obs_q.size() != 1) begin err_cnt++; $display("FAIL arst_nostrobe got %0d want 1", obs_q.size()); end
    vec_cnt++; if (bus.Level_o !== 4'd0) begin err_cnt++; $display("FAIL arst_after got %0d want 0", bus.Level_o); end
  endtask

  initial begin
    SYS_nRST       = 1'b0;
    bus.WrReq_i    = 1'b0;
    bus.WrVector_i = '0;
    bus.VBlank_i   = 1'b0;
    bus.Flush_i    = 1'b0;
    bus.OvfClr_i   = 1'b0;
    @(negedge SYS_CLK);
    test_reset();
    test_latency();
    test_overflow();
    test_vblank_pause();
    test_full_push_pop();
    test_flush();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/osd_wr_scheduler.md
OSD_WR_SCHEDULER -- requirements
Module: osd_wr_scheduler

Interface
REQ-001 Parameter: FIFO_AW, 3, log2 of write FIFO depth; depth = 2^FIFO_AW = 8.
REQ-002 Parameter: WR_GAP, 2, idle cycles inserted after each issued OSD write; 0 = back-to-back.
REQ-003 Clocking: one clock, SYS_CLK; reset SYS_nRST is asynchronous and active-low.
REQ-004 SYS_CLK  in  1  system clock; all logic on rising edge.
REQ-005 SYS_nRST  in  1  asynchronous active-low reset.
REQ-006 WrReq_i  in  1  CPU write strobe; one push per high cycle.
REQ-007 WrVector_i  in  25  {wrctrl[1:0], wrdata[22:0]} CPU OSD write word; sampled when WrReq_i = 1.
REQ-008 VBlank_i  in  1  resynced OSD vertical-blank level; 1 = OSD RAM writes permitted.
REQ-009 Flush_i  in  1  synchronous FIFO discard request.
REQ-010 OvfClr_i  in  1  clears the sticky overflow flag.
REQ-011 OSDWrVector_o  out  25  registered write word to OSD RAM.
REQ-012 OSDWrEn_o  out  1  registered one-cycle write strobe qualifying OSDWrVector_o.
REQ-013 Level_o  out  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW.
REQ-014 Full_o  out  1  Level_o == 2^FIFO_AW.
REQ-015 Overflow_o  out  1  sticky: a push was dropped.

Function
REQ-016 FIFO: circular buffer, FIFO_AW-bit read/write pointers wrapping modulo depth; occupancy counter FIFO_AW+1 bits.
REQ-017 Push: WrReq_i = 1 and (not full, or pop in same cycle) stores WrVector_i; push while full without pop is dropped and sets Overflow_o.
REQ-018 Simultaneous push and pop: both executed; Level_o unchanged.
REQ-019 FSM states: ST_IDLE, ST_WAIT4VB, ST_ISSUE, ST_GAP.
REQ-020 ST_IDLE: FIFO non-empty -> ST_WAIT4VB.
REQ-021 ST_WAIT4VB: VBlank_i = 1 and FIFO non-empty -> ST_ISSUE; FIFO empty -> ST_IDLE.
REQ-022 ST_ISSUE: pops head word, drives OSDWrVector_o <= head and OSDWrEn_o <= 1 next cycle; -> ST_GAP if WR_GAP > 0, else evaluates as ST_WAIT4VB in the same transition.
REQ-023 ST_GAP: gap counter counts WR_GAP cycles; on expiry -> ST_WAIT4VB.
REQ-024 OSDWrEn_o high for exactly one cycle per popped word; low otherwise; OSDWrVector_o holds last issued word between strobes.
REQ-025 Latency: push at cycle n into empty FIFO with VBlank_i = 1 and FSM in ST_IDLE -> OSDWrEn_o high at cycle n+3.
REQ-026 VBlank_i falling while in ST_GAP or ST_ISSUE: word already popped still issues; no further pop until VBlank_i = 1 again.
REQ-027 Order: words issue strictly in push order; none duplicated or lost except by overflow or flush.
REQ-028 Flush_i: next cycle pointers equal, Level_o = 0, FSM -> ST_IDLE, gap counter cleared; push in the same cycle dropped without setting Overflow_o; pending ST_ISSUE output is suppressed.
REQ-029 OvfClr_i and a dropped push in the same cycle: Overflow_o remains 1 (set wins).
REQ-030 Width rules: pointer and counter arithmetic unsigned and modulo their width; gap counter width clog2(WR_GAP+1), min 1.

Reset
REQ-031 SYS_nRST low: FSM ST_IDLE, pointers 0, Level_o 0, Full_o 0, Overflow_o 0, OSDWrEn_o 0, OSDWrVector_o 25'h0, gap counter 0.
REQ-032 Reset mid-drain: all queued words discarded; no OSDWrEn_o pulse after deassertion until a new push.
REQ-033 FIFO storage array not reset; contents beyond occupancy are don't-care.

Structure
REQ-034 FSM state encodings and OSD write vector width (25) live in the shared lib config header alongside the existing OSD/PPU defines.
REQ-035 One sub-module, osd_wr_fifo (storage, pointers, occupancy, full/empty); FSM and gap counter in osd_wr_scheduler.

Verification
REQ-036 VBlank_i = 1, push 25'h1ABCDEF at cycle 0 -> OSDWrEn_o = 1 at cycle 3 with OSDWrVector_o = 25'h1ABCDEF, one cycle only.
REQ-037 VBlank_i = 0, push 9 words -> Level_o = 8, Full_o = 1, Overflow_o = 1, zero strobes; raise VBlank_i -> first 8 words issue in order, spaced WR_GAP+1 = 3 cycles.
REQ-038 Drain active, drop VBlank_i right after a pop -> exactly that word issues, rest held; VBlank_i = 1 resumes with next word.
REQ-039 Full FIFO, push and pop same cycle -> Level_o stays 8, Overflow_o stays 0, pushed word issues last.
REQ-040 Flush_i with Level_o = 5 and concurrent WrReq_i -> Level_o = 0 next cycle, Overflow_o = 0, no strobes follow.
REQ-041 Assert SYS_nRST low mid-drain for 1 cycle asynchronously -> all outputs at REQ-031 values immediately, no strobes after release.
